// File: rtl/cascaded_digit_counter.sv
// -----------------------------------------------------------------------------
// cascaded_digit_counter
//   NUM_DIGITS-digit up/down counter in radix BASE, one nybble per digit
//   (BCD when BASE=10). Digits are cascaded with lookahead carry/borrow, so a
//   full multi-digit rollover lands in a single cycle. Supports synchronous
//   parallel load with per-digit clamping, wrap or saturate at the terminal
//   value, and a registered terminal-event pulse plus sticky overflow flag.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   enable          count one step this cycle
//   up_down         1 = increment, 0 = decrement
//   saturate        1 = hold at terminal value, 0 = wrap
//   load            synchronous parallel load (beats enable)
//   load_value      value to load, nybble i = digit i (clamped to BASE-1)
//   clear_sticky    clears overflow_sticky (a same-edge set wins)
//   count           current count, nybble i = digit i
//   digit_tc        bit i = digit i at its terminal value for up_down
//   terminal        all digits at terminal value (combinational)
//   tc_pulse        registered pulse: the previous edge took a terminal step
//   overflow_sticky set on every terminal step, held until cleared
// -----------------------------------------------------------------------------

// Per-digit next-state and terminal detect. Purely combinational; the digit
// flops live in the top so reset and the register bank stay in one place.
module cascaded_digit_counter_digit #(
   parameter int BASE = 10
) (
   input  logic [3:0] digit,
   input  logic       up_down,
   input  logic       load,
   input  logic [3:0] load_nyb,
   input  logic       step,
   output logic [3:0] digit_d,
   output logic       tc
);
   localparam logic [3:0] MAXD  = 4'(BASE - 1);
   localparam logic [4:0] BASE5 = 5'(BASE);

   always_comb begin
      tc      = up_down ? (digit == MAXD) : (digit == 4'd0);
      digit_d = digit;
      if (load) begin
         digit_d = ({1'b0, load_nyb} >= BASE5) ? MAXD : load_nyb;
      end else if (step) begin
         // Out-of-range values fall into the wrap branch so they cannot lock up.
         if (up_down) digit_d = (digit >= MAXD) ? 4'd0 : digit + 4'd1;
         else         digit_d = ((digit == 4'd0) || (digit > MAXD)) ? MAXD : digit - 4'd1;
      end
   end
endmodule

module cascaded_digit_counter #(
   parameter int BASE       = 10,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    up_down,
   input  logic                    saturate,
   input  logic                    load,
   input  logic [NUM_DIGITS*4-1:0] load_value,
   input  logic                    clear_sticky,
   output logic [NUM_DIGITS*4-1:0] count,
   output logic [NUM_DIGITS-1:0]   digit_tc,
   output logic                    terminal,
   output logic                    tc_pulse,
   output logic                    overflow_sticky
);
   logic [NUM_DIGITS-1:0][3:0] count_q, count_d, load_nyb;
   logic [NUM_DIGITS-1:0]      chg, step;
   logic                       term_step;
   logic                       tc_pulse_q, tc_pulse_d;
   logic                       sticky_q, sticky_d;

   assign load_nyb = load_value;
   assign terminal = &digit_tc;

   // Lookahead: digit i moves when every lower digit sits at its terminal
   // value. Each chg[i] is a direct AND of the lower tc bits, no ripple.
   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         chg[i] = 1'b1;
         for (int j = 0; j < i; j++) chg[i] = chg[i] & digit_tc[j];
      end
   end

   // Saturating terminal step freezes every digit; otherwise the all-tc
   // lookahead makes every digit wrap together.
   always_comb begin
      term_step = enable & ~load & terminal;
      for (int i = 0; i < NUM_DIGITS; i++)
         step[i] = enable & ~load & chg[i] & ~(saturate & terminal);
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      cascaded_digit_counter_digit #(.BASE(BASE)) u_digit (
         .digit    (count_q[g]),
         .up_down  (up_down),
         .load     (load),
         .load_nyb (load_nyb[g]),
         .step     (step[g]),
         .digit_d  (count_d[g]),
         .tc       (digit_tc[g])
      );
   end

   always_comb begin
      tc_pulse_d = term_step;
      sticky_d   = sticky_q;
      if (clear_sticky) sticky_d = 1'b0;
      if (term_step)    sticky_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         tc_pulse_q <= 1'b0;
         sticky_q   <= 1'b0;
      end else begin
         count_q    <= count_d;
         tc_pulse_q <= tc_pulse_d;
         sticky_q   <= sticky_d;
      end
   end

   assign count           = count_q;
   assign tc_pulse        = tc_pulse_q;
   assign overflow_sticky = sticky_q;
endmodule

// File: tb/tb_cascaded_digit_counter.sv
// Bench for cascaded_digit_counter: a BASE=10/4-digit and a BASE=6/2-digit
// instance share controls; each is compared every cycle against an
// integer-valued model (count held as a plain number modulo BASE**N).
module tb_cascaded_digit_counter;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable, up_down, saturate, load, clear_sticky;
   logic [15:0] a_lv;
   logic [7:0]  b_lv;
   logic [15:0] a_count;
   logic [3:0]  a_dtc;
   logic        a_term, a_tc, a_st;
   logic [7:0]  b_count;
   logic [1:0]  b_dtc;
   logic        b_term, b_tc, b_st;

   int n_chk  = 0;
   int n_fail = 0;
   int mb[2]  = '{10, 6};
   int mn[2]  = '{4, 2};
   int mv[2];
   bit mtc[2];
   bit mst[2];

   always #5 clk = ~clk;

   cascaded_digit_counter #(.BASE(10), .NUM_DIGITS(4)) u_a (
      .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .saturate(saturate),
      .load(load), .load_value(a_lv), .clear_sticky(clear_sticky), .count(a_count),
      .digit_tc(a_dtc), .terminal(a_term), .tc_pulse(a_tc), .overflow_sticky(a_st));

   cascaded_digit_counter #(.BASE(6), .NUM_DIGITS(2)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .saturate(saturate),
      .load(load), .load_value(b_lv), .clear_sticky(clear_sticky), .count(b_count),
      .digit_tc(b_dtc), .terminal(b_term), .tc_pulse(b_tc), .overflow_sticky(b_st));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int pw(input int b, input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   function automatic logic [31:0] enc(input int b, input int n, input int v);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[4*i +: 4] = 4'((v / pw(b, i)) % b);
      return r;
   endfunction

   function automatic int dec_clamp(input int b, input int n, input logic [31:0] lv);
      int v = 0;
      for (int i = 0; i < n; i++) begin
         int d = int'(lv[4*i +: 4]);
         if (d >= b) d = b - 1;
         v += d * pw(b, i);
      end
      return v;
   endfunction

   function automatic logic [31:0] dtc(input int b, input int n, input int v, input bit ud);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r[i] = (((v / pw(b, i)) % b) == (ud ? b - 1 : 0));
      return r;
   endfunction

   task automatic model_edge(input int k, input logic [31:0] lv);
      int  mx   = pw(mb[k], mn[k]) - 1;
      bit  term = up_down ? (mv[k] == mx) : (mv[k] == 0);
      mtc[k] = 1'b0;
      if (clear_sticky) mst[k] = 1'b0;
      if (load) mv[k] = dec_clamp(mb[k], mn[k], lv);
      else if (enable) begin
         if (term) begin
            mtc[k] = 1'b1;
            mst[k] = 1'b1;
            if (!saturate) mv[k] = up_down ? 0 : mx;
         end else mv[k] = up_down ? mv[k] + 1 : mv[k] - 1;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mv[k] = 0; mtc[k] = 1'b0; mst[k] = 1'b0;
      end
   endtask

   task automatic check_comb();
      chk("a_dtc",  a_dtc,  dtc(10, 4, mv[0], up_down));
      chk("a_term", a_term, mv[0] == (up_down ? 9999 : 0));
      chk("b_dtc",  b_dtc,  dtc(6, 2, mv[1], up_down));
      chk("b_term", b_term, mv[1] == (up_down ? 35 : 0));
   endtask

   task automatic check_regs();
      chk("a_count",  a_count, enc(10, 4, mv[0]));
      chk("a_tc",     a_tc,    mtc[0]);
      chk("a_sticky", a_st,    mst[0]);
      chk("b_count",  b_count, enc(6, 2, mv[1]));
      chk("b_tc",     b_tc,    mtc[1]);
      chk("b_sticky", b_st,    mst[1]);
   endtask

   // One clock: drive at the falling edge, check combinational outputs,
   // advance the model, check registered outputs just after the rising edge.
   task automatic cyc(input bit en, input bit ud, input bit sat, input bit ld,
                      input logic [15:0] lv, input bit clr);
      enable = en; up_down = ud; saturate = sat; load = ld; clear_sticky = clr;
      a_lv = lv; b_lv = lv[7:0];
      #1;
      check_comb();
      model_edge(0, {16'h0, lv});
      model_edge(1, {24'h0, lv[7:0]});
      @(posedge clk); #1;
      check_regs();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; enable = 0; up_down = 1; saturate = 0; load = 0; clear_sticky = 0;
      a_lv = '0; b_lv = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_regs();
      rst = 1'b1;

      // Lookahead carry across three digits
      cyc(0, 1, 0, 1, 16'h0999, 0);
      up_down = 1'b1; #1;
      chk("t1_dtc", a_dtc, 4'b0111);
      cyc(1, 1, 0, 0, 16'h0, 0);
      chk("t1_cnt", a_count, 16'h1000);

      // Full wrap up, single tc pulse
      cyc(0, 1, 0, 1, 16'h9999, 0);
      cyc(1, 1, 0, 0, 16'h0, 0);
      chk("t2_cnt", a_count, 16'h0000);
      chk("t2_tc", a_tc, 1'b1);
      chk("t2_st", a_st, 1'b1);
      cyc(0, 1, 0, 0, 16'h0, 0);
      chk("t2_tc_off", a_tc, 1'b0);

      // Saturate at zero counting down; set beats clear
      cyc(0, 0, 1, 1, 16'h0000, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 0, 16'h0, 0);
         chk("t3_cnt", a_count, 16'h0000);
         chk("t3_tc", a_tc, 1'b1);
      end
      cyc(1, 0, 1, 0, 16'h0, 1);
      chk("t3_st", a_st, 1'b1);

      // Load clamping and load-over-enable priority
      cyc(0, 1, 0, 1, 16'hF3A1, 0);
      chk("t4_clamp", a_count, 16'h9391);
      cyc(1, 1, 0, 1, 16'h1234, 0);
      chk("t4_prio", a_count, 16'h1234);
      chk("t4_tc", a_tc, 1'b0);

      // BASE=6 direction toggling
      cyc(0, 1, 0, 1, 16'h0055, 0);
      up_down = 1'b0; #1;
      chk("t5_term_dn", b_term, 1'b0);
      up_down = 1'b1; #1;
      chk("t5_term_up", b_term, 1'b1);
      cyc(1, 0, 0, 0, 16'h0, 0);
      chk("t5_a", b_count, 8'h54);
      cyc(1, 1, 0, 0, 16'h0, 0);
      chk("t5_b", b_count, 8'h55);
      cyc(1, 0, 0, 0, 16'h0, 0);
      chk("t5_c", b_count, 8'h54);

      // Asynchronous reset between edges
      cyc(0, 1, 0, 1, 16'h0122, 0);
      cyc(1, 1, 0, 0, 16'h0, 0);
      chk("t6_pre", a_count, 16'h0123);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("t6_cnt", a_count, 16'h0000);
      chk("t6_tc", a_tc, 1'b0);
      chk("t6_st", a_st, 1'b0);
      @(negedge clk);
      check_regs();
      rst = 1'b1;
      cyc(1, 1, 0, 0, 16'h0, 0);
      chk("t6_post", a_count, 16'h0001);

      // Randomized traffic; loads often land near terminal values
      for (int i = 0; i < 400; i++) begin
         logic [15:0] lv;
         bit ud;
         lv = 16'($urandom);
         case ($urandom_range(0, 3))
            0: lv = 16'h9999;
            1: lv = 16'h0000;
            default: ;
         endcase
         ud = ($urandom_range(0, 3) == 0) ? ~up_down : up_down;
         cyc($urandom_range(0, 3) != 0, ud, 1'($urandom), $urandom_range(0, 9) == 0,
             lv, $urandom_range(0, 7) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
